clock_div_multi: RTL and testbench

CLOCK_DIV_MULTI -- requirements
Module: clock_div_multi

---
 rtl/clock_gen_pkg.sv | 15 +
 rtl/clock_div_multi_if.sv | 26 ++
 rtl/clk_div_ch.sv | 63 ++++++
 rtl/clock_div_multi.sv | 97 +++++++++
 tb/tb_clock_div_multi.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/clock_gen_pkg.sv
// Shared types and default constants for the multi-channel clock-enable divider.
package clock_gen_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        LOCKED    = 2'd2
    } lock_state_e;

    localparam int DEF_NUM_CH      = 3;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_LOCK_CYCLES = 1024;
    localparam int DEF_DIV_INIT    = 2;

endpackage

// File: rtl/clock_div_multi_if.sv
// Control and status bundle of clock_div_multi; the clock and reset stay plain ports.
interface clock_div_multi_if
    import clock_gen_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
);
    logic                    resync;
    logic [NUM_CH*CNT_W-1:0] div_val;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       clk_en;
    logic [NUM_CH-1:0]       clk_sq;
    logic                    locked;
    logic                    rst_out_n;

    modport master (
        output resync, div_val, div_load, ch_en,
        input  clk_en, clk_sq, locked, rst_out_n
    );

    modport slave (
        input  resync, div_val, div_load, ch_en,
        output clk_en, clk_sq, locked, rst_out_n
    );
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, shadowed divide value, enable pulse and square wave.
module clk_div_ch
    import clock_gen_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DIV_INIT = DEF_DIV_INIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             live,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             clk_en,
    output logic             clk_sq
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] shadow_eff;
    logic             running;
    logic             wrap;
    logic             sq_nxt;

    // High phase length; odd divide values give the extra cycle to the high phase.
    function automatic logic [CNT_W:0] ceil_half(input logic [CNT_W-1:0] d);
        return ({1'b0, d} + (CNT_W+1)'(1)) >> 1;
    endfunction

    always_comb begin
        shadow_eff = load ? load_val : shadow;
        running    = step && en && (div != '0);
        wrap       = running && (cnt == div - CNT_W'(1));
        cnt_nxt    = '0;
        if (running && !wrap) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
        // A new divide value only lands on a period boundary, or at once when idle.
        div_nxt = (wrap || !running) ? shadow_eff : div;
        sq_nxt  = live && en && (div_nxt != '0) && ({1'b0, cnt_nxt} < ceil_half(div_nxt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            div    <= CNT_W'(DIV_INIT);
            shadow <= CNT_W'(DIV_INIT);
            clk_en <= 1'b0;
            clk_sq <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            div    <= div_nxt;
            shadow <= shadow_eff;
            clk_en <= wrap;
            clk_sq <= sq_nxt;
        end
    end

endmodule

// File: rtl/clock_div_multi.sv
// Lock sequencer plus NUM_CH phase-aligned clock-enable dividers running on inclk0.
module clock_div_multi
    import clock_gen_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int DIV_INIT    = DEF_DIV_INIT
) (
    input logic               inclk0,
    input logic               areset_n,
    clock_div_multi_if.slave  bus
);

    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    lock_state_e       state;
    lock_state_e       state_nxt;
    logic [LCW-1:0]    lock_cnt;
    logic [LCW-1:0]    lock_cnt_nxt;
    logic              locked_q;
    logic              step;
    logic              live;
    logic [NUM_CH-1:0] clk_en_v;
    logic [NUM_CH-1:0] clk_sq_v;

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            state    <= IDLE;
            lock_cnt <= '0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            locked_q <= (state_nxt == LOCKED);
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        case (state)
            IDLE: begin
                state_nxt    = WAIT_LOCK;
                lock_cnt_nxt = '0;
            end
            WAIT_LOCK: begin
                if (bus.resync) begin
                    lock_cnt_nxt = '0;
                end else if (lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
                    state_nxt    = LOCKED;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + LCW'(1);
                end
            end
            LOCKED: begin
                if (bus.resync) begin
                    state_nxt    = WAIT_LOCK;
                    lock_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // Counters advance only on edges that stay inside LOCKED; entering LOCKED starts all at 0.
    always_comb begin
        step          = (state == LOCKED) && (state_nxt == LOCKED);
        live          = (state_nxt == LOCKED);
        bus.locked    = (state == LOCKED);
        bus.rst_out_n = locked_q;
        bus.clk_en    = clk_en_v;
        bus.clk_sq    = clk_sq_v;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk      (inclk0),
            .rst_n    (areset_n),
            .step     (step),
            .live     (live),
            .en       (bus.ch_en[i]),
            .load     (bus.div_load[i]),
            .load_val (bus.div_val[i*CNT_W +: CNT_W]),
            .clk_en   (clk_en_v[i]),
            .clk_sq   (clk_sq_v[i])
        );
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Scoreboard bench for clock_div_multi: directed scenarios plus randomized traffic vs a reference model.
module tb_clock_div_multi;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int LC  = 8;
    localparam int DI  = 2;

    logic clk      = 1'b0;
    logic areset_n = 1'b0;
    bit   rst_req  = 1'b0;

    clock_div_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    clock_div_multi #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .LOCK_CYCLES (LC),
        .DIV_INIT    (DI)
    ) dut (
        .inclk0   (clk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           lk;
        logic           rn;
        logic [NCH-1:0] en;
        logic [NCH-1:0] sq;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;

    // Reference model: edges since the lock sequence (re)started, and per-channel period position.
    int   m_age;
    int   m_d[NCH];
    int   m_sh[NCH];
    int   m_pos[NCH];
    exp_t m_out;

    function automatic void chk(string name, logic [7:0] act, logic [7:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, req);
    endfunction

    function automatic void model_reset();
        m_age = 0;
        for (int i = 0; i < NCH; i++) begin
            m_d[i]   = DI;
            m_sh[i]  = DI;
            m_pos[i] = 0;
        end
        m_out = '0;
    endfunction

    function automatic void model_edge(bit rs, logic [NCH-1:0] ld, logic [NCH-1:0] en, int v[NCH]);
        bit was_locked, now_locked, adv, boundary;
        int sh;
        was_locked = (m_age >= LC + 1);
        if (rs && m_age >= 1) m_age = 1;
        else if (m_age < LC + 1) m_age++;
        now_locked = (m_age >= LC + 1);
        m_out.lk = now_locked;
        m_out.rn = now_locked;
        for (int i = 0; i < NCH; i++) begin
            sh = ld[i] ? v[i] : m_sh[i];
            m_sh[i] = sh;
            adv = was_locked && now_locked && en[i] && (m_d[i] > 0);
            boundary = adv && (m_pos[i] == m_d[i] - 1);
            m_out.en[i] = boundary;
            m_pos[i] = adv ? (m_pos[i] + 1) % m_d[i] : 0;
            if (boundary || !adv) m_d[i] = sh;
            m_out.sq[i] = now_locked && en[i] && (m_d[i] > 0) && (m_pos[i] < (m_d[i] + 1) / 2);
        end
    endfunction

    task automatic cycle(input bit rs, input logic [NCH-1:0] ld, input logic [NCH-1:0] en,
                         input int v0, input int v1, input int v2);
        int v[NCH];
        logic [NCH*CW-1:0] dv;
        v[0] = v0; v[1] = v1; v[2] = v2;
        dv = '0;
        for (int i = 0; i < NCH; i++) dv[i*CW +: CW] = CW'(v[i]);
        @(negedge clk);
        areset_n     = rst_req;
        bus.resync   = rs;
        bus.div_load = ld;
        bus.ch_en    = en;
        bus.div_val  = dv;
        if (!rst_req) model_reset();
        else model_edge(rs, ld, en, v);
        q.push_back(m_out);
    endtask

    task automatic idle(input int n, input logic [NCH-1:0] en);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, en, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("locked",    8'(bus.locked),    8'(e.lk));
                chk("rst_out_n", 8'(bus.rst_out_n), 8'(e.rn));
                chk("clk_en",    8'(bus.clk_en),    8'(e.en));
                chk("clk_sq",    8'(bus.clk_sq),    8'(e.sq));
            end
        end
    end

    initial begin : driver
        int n;
        bit found;
        logic [NCH-1:0] en_r;
        bus.resync   = 1'b0;
        bus.div_load = '0;
        bus.ch_en    = '1;
        bus.div_val  = '0;
        model_reset();

        idle(3, '1);
        rst_req = 1'b1;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, '0, '1, 0, 0, 0);
            @(posedge clk);
            #2;
            n = k;
            if (bus.locked) break;
        end
        chk("lock_latency", 8'(n), 8'(LC + 1));
        idle(6, '1);

        // Aligned restart with D = 2, 3, 5.
        cycle(1'b1, 3'b111, '1, 2, 3, 5);
        idle(45, '1);

        // Relock with D0 = 4, then shrink it to 2 at count 1.
        cycle(1'b1, 3'b001, '1, 4, 0, 0);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_age >= LC + 1 && m_d[0] == 4 && m_pos[0] == 1) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, '0, '1, 0, 0, 0);
        end
        chk("reach_count1", 8'(found), 8'd1);
        cycle(1'b0, 3'b001, '1, 2, 0, 0);
        idle(15, '1);

        // D = 0 on channel 1 and D = 1 on channel 2.
        cycle(1'b0, 3'b110, '1, 0, 0, 1);
        idle(20, '1);

        // Resync while locked.
        cycle(1'b1, '0, '1, 0, 0, 0);
        idle(20, '1);

        en_r = '1;
        for (int k = 0; k < 300; k++) begin
            bit rs;
            logic [NCH-1:0] ld;
            for (int i = 0; i < NCH; i++) if ($urandom_range(0, 39) == 0) en_r[i] = ~en_r[i];
            rs = ($urandom_range(0, 79) == 0);
            ld = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
            cycle(rs, ld, en_r, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
        end

        // Mid-period asynchronous reset.
        cycle(1'b0, 3'b111, '1, 3, 4, 5);
        idle(LC + 6, '1);
        @(posedge clk);
        #3;
        rst_req  = 1'b0;
        areset_n = 1'b0;
        #1;
        chk("async_locked",    8'(bus.locked),    8'd0);
        chk("async_rst_out_n", 8'(bus.rst_out_n), 8'd0);
        chk("async_clk_en",    8'(bus.clk_en),    8'd0);
        chk("async_clk_sq",    8'(bus.clk_sq),    8'd0);
        model_reset();
        idle(3, '1);
        rst_req = 1'b1;
        idle(LC + 12, '1);

        @(posedge clk);
        #3;
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
